synth_cfg_mmio: RTL and testbench

SYNTH_CFG_MMIO -- requirements
Module: synth_cfg_mmio

---
 rtl/synth_cfg_mmio.sv | 148 ++++++++++++++
 tb/tb_synth_cfg_mmio.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/synth_cfg_mmio.sv
// MMIO shadow/commit register block for the FM synth with a 4-phase req/ack handshake.
// Define SYNTH_CFG_AUTO_COMMIT_EN to make every mapped shadow write also request a commit.
module synth_cfg_mmio #(
  parameter int N_VOICES = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic                     rd_en,
  input  logic [7:0]               addr,
  input  logic [31:0]              wdata,
  output logic [31:0]              rdata,
  output logic                     req,
  input  logic                     ack,
  output logic [N_VOICES*24-1:0]   carrier_fcws,
  output logic [23:0]              mod_fcw,
  output logic [4:0]               mod_shift,
  output logic [N_VOICES-1:0]      note_en,
  output logic [4:0]               synth_shift
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RELEASE} state_t;

  state_t state, state_nxt;
  logic   pending, pending_nxt;

  logic [5:0]             word;
  logic                   carrier_hit;
  logic                   commit;
  logic                   load;
  logic [31:0]            rd_val;
  logic                   unused_bits;

  logic [23:0]            sh_mod_fcw, mod_fcw_nxt;
  logic [4:0]             sh_mod_shift, mod_shift_nxt;
  logic [4:0]             sh_synth_shift, synth_shift_nxt;
  logic [N_VOICES-1:0]    sh_note_en, note_en_nxt;
  logic [N_VOICES*24-1:0] sh_carrier, carrier_nxt;

  assign word        = addr[7:2];
  assign carrier_hit = (word[5:3] == 3'b010) && ({29'd0, word[2:0]} < 32'(N_VOICES));
  assign unused_bits = ^{addr[1:0], wdata[31:24]};

`ifdef SYNTH_CFG_AUTO_COMMIT_EN
  assign commit = wr_en && ((word == 6'd4) || (word <= 6'd3) || carrier_hit);
`else
  assign commit = wr_en && (word == 6'd4);
`endif

  // Shadow values after this cycle's write, so a same-cycle commit captures the new data
  always_comb begin
    mod_fcw_nxt     = sh_mod_fcw;
    mod_shift_nxt   = sh_mod_shift;
    synth_shift_nxt = sh_synth_shift;
    note_en_nxt     = sh_note_en;
    carrier_nxt     = sh_carrier;
    if (wr_en) begin
      case (word)
        6'd0:    mod_fcw_nxt     = wdata[23:0];
        6'd1:    mod_shift_nxt   = wdata[4:0];
        6'd2:    synth_shift_nxt = wdata[4:0];
        6'd3:    note_en_nxt     = wdata[N_VOICES-1:0];
        default: ;
      endcase
      for (int i = 0; i < N_VOICES; i++) begin
        if (carrier_hit && (word[2:0] == 3'(i))) carrier_nxt[i*24 +: 24] = wdata[23:0];
      end
    end
  end

  always_comb begin
    rd_val = '0;
    case (word)
      6'd0: rd_val = {8'd0, sh_mod_fcw};
      6'd1: rd_val = {27'd0, sh_mod_shift};
      6'd2: rd_val = {27'd0, sh_synth_shift};
      6'd3: rd_val[N_VOICES-1:0] = sh_note_en;
      6'd5: rd_val = {30'd0, pending, (state != S_IDLE)};
      default: begin
        for (int i = 0; i < N_VOICES; i++) begin
          if (carrier_hit && (word[2:0] == 3'(i))) rd_val = {8'd0, sh_carrier[i*24 +: 24]};
        end
      end
    endcase
  end

  // Commits arriving mid-handshake collapse into a single pending flag
  always_comb begin
    state_nxt   = state;
    pending_nxt = pending;
    load        = 1'b0;
    case (state)
      S_IDLE: begin
        if (commit || pending) begin
          load        = 1'b1;
          pending_nxt = 1'b0;
          state_nxt   = S_REQ;
        end
      end
      S_REQ: begin
        if (commit) pending_nxt = 1'b1;
        if (ack) state_nxt = S_RELEASE;
      end
      S_RELEASE: begin
        if (commit) pending_nxt = 1'b1;
        if (!ack) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign req = (state == S_REQ);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_IDLE;
      pending        <= 1'b0;
      rdata          <= '0;
      sh_mod_fcw     <= '0;
      sh_mod_shift   <= '0;
      sh_synth_shift <= '0;
      sh_note_en     <= '0;
      sh_carrier     <= '0;
      mod_fcw        <= '0;
      mod_shift      <= '0;
      synth_shift    <= '0;
      note_en        <= '0;
      carrier_fcws   <= '0;
    end else begin
      state          <= state_nxt;
      pending        <= pending_nxt;
      sh_mod_fcw     <= mod_fcw_nxt;
      sh_mod_shift   <= mod_shift_nxt;
      sh_synth_shift <= synth_shift_nxt;
      sh_note_en     <= note_en_nxt;
      sh_carrier     <= carrier_nxt;
      if (rd_en) rdata <= rd_val;
      if (load) begin
        mod_fcw      <= mod_fcw_nxt;
        mod_shift    <= mod_shift_nxt;
        synth_shift  <= synth_shift_nxt;
        note_en      <= note_en_nxt;
        carrier_fcws <= carrier_nxt;
      end
    end
  end

endmodule

// File: tb/tb_synth_cfg_mmio.sv
// Self-checking bench for synth_cfg_mmio: directed handshake scenarios plus randomized
// MMIO traffic compared against a word-map reference model.
module tb_synth_cfg_mmio;

  localparam int NV = 4;
  localparam int P_IDLE = 0;
  localparam int P_REQ  = 1;
  localparam int P_REL  = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            wr_en, rd_en, ack;
  logic [7:0]      addr;
  logic [31:0]     wdata;
  logic [31:0]     rdata;
  logic            req;
  logic [NV*24-1:0] carrier_fcws;
  logic [23:0]     mod_fcw;
  logic [4:0]      mod_shift;
  logic [NV-1:0]   note_en;
  logic [4:0]      synth_shift;

  int checks = 0;
  int errors = 0;

  bit [31:0] m_sh  [64];
  bit [31:0] m_out [64];
  bit [31:0] m_rdata;
  bit        m_pend;
  int        phase;

  synth_cfg_mmio #(.N_VOICES(NV)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .addr(addr), .wdata(wdata),
    .rdata(rdata), .req(req), .ack(ack), .carrier_fcws(carrier_fcws), .mod_fcw(mod_fcw),
    .mod_shift(mod_shift), .note_en(note_en), .synth_shift(synth_shift)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  function automatic bit is_mapped(int w);
    return (w <= 3) || (w >= 16 && w < 16 + NV);
  endfunction

  function automatic bit [31:0] field_mask(int w);
    case (w)
      0:       return 32'h00FF_FFFF;
      1, 2:    return 32'h0000_001F;
      3:       return (32'd1 << NV) - 32'd1;
      default: return 32'h00FF_FFFF;
    endcase
  endfunction

  function automatic void model_reset();
    foreach (m_sh[i]) begin
      m_sh[i]  = '0;
      m_out[i] = '0;
    end
    m_rdata = '0;
    m_pend  = 1'b0;
    phase   = P_IDLE;
  endfunction

  // Reference behaviour of one clock edge, derived from the register map and handshake rules
  function automatic void model_step(bit w, bit r, bit [7:0] a, bit [31:0] d, bit k);
    int wd;
    bit commit;
    wd = int'(a[7:2]);
    if (r) begin
      if (wd == 5)             m_rdata = {30'd0, m_pend, phase != P_IDLE};
      else if (is_mapped(wd))  m_rdata = m_sh[wd];
      else                     m_rdata = '0;
    end
    if (w && is_mapped(wd)) m_sh[wd] = d & field_mask(wd);
`ifdef SYNTH_CFG_AUTO_COMMIT_EN
    commit = w && (wd == 4 || is_mapped(wd));
`else
    commit = w && (wd == 4);
`endif
    case (phase)
      P_IDLE: begin
        if (commit || m_pend) begin
          foreach (m_sh[i]) m_out[i] = m_sh[i];
          m_pend = 1'b0;
          phase  = P_REQ;
        end
      end
      P_REQ: begin
        if (commit) m_pend = 1'b1;
        if (k) phase = P_REL;
      end
      default: begin
        if (commit) m_pend = 1'b1;
        if (!k) phase = P_IDLE;
      end
    endcase
  endfunction

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_output();
    logic [NV*24-1:0] exp_car;
    exp_car = '0;
    for (int i = 0; i < NV; i++) exp_car[i*24 +: 24] = m_out[16+i][23:0];
    check("req",          96'(req),          96'(phase == P_REQ));
    check("mod_fcw",      96'(mod_fcw),      96'(m_out[0][23:0]));
    check("mod_shift",    96'(mod_shift),    96'(m_out[1][4:0]));
    check("synth_shift",  96'(synth_shift),  96'(m_out[2][4:0]));
    check("note_en",      96'(note_en),      96'(m_out[3][NV-1:0]));
    check("carrier_fcws", 96'(carrier_fcws), 96'(exp_car));
    check("rdata",        96'(rdata),        96'(m_rdata));
  endtask

  task automatic apply_stimulus(input logic w, input logic r, input logic [7:0] a,
                                input logic [31:0] d, input logic k);
    wr_en = w; rd_en = r; addr = a; wdata = d; ack = k;
    @(posedge clk);
    model_step(w, r, a, d, k);
    #1;
    check_output();
    @(negedge clk);
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 8; n++) begin
      if (phase == P_IDLE && !m_pend) break;
      apply_stimulus(0, 0, 8'h00, 0, 1'b1);
      apply_stimulus(0, 0, 8'h00, 0, 1'b0);
    end
    apply_stimulus(0, 0, 8'h00, 0, 1'b0);
    check("drain_idle", 96'(req), 96'(0));
  endtask

  initial begin
    logic [7:0] addr_pool [12];
    logic [7:0] a;
    addr_pool = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h40, 8'h44, 8'h48, 8'h4C, 8'h50, 8'h20};

    rst = 1'b1; wr_en = 0; rd_en = 0; ack = 0; addr = 0; wdata = 0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_output();
    rst = 1'b0;

    // Basic commit and handshake
    apply_stimulus(1, 0, 8'h00, 32'h0012_3456, 0);
    apply_stimulus(1, 0, 8'h10, 32'hDEAD_BEEF, 0);
    check("t1_req", 96'(req), 96'(1));
    check("t1_fcw", 96'(mod_fcw), 96'(24'h123456));
    apply_stimulus(0, 0, 8'h00, 0, 1);
    check("t1_req_drop", 96'(req), 96'(0));
    apply_stimulus(0, 0, 8'h00, 0, 0);
    drain();
    apply_stimulus(0, 1, 8'h14, 0, 0);
    check("t1_status", 96'(rdata), 96'(0));

    // Commits during a handshake collapse into one pending
    apply_stimulus(1, 0, 8'h10, 0, 0);
    apply_stimulus(1, 0, 8'h0C, 32'h1, 0);
    apply_stimulus(1, 0, 8'h10, 0, 0);
    apply_stimulus(1, 0, 8'h10, 0, 0);
    check("t2_note_old", 96'(note_en), 96'(0));
    apply_stimulus(0, 1, 8'h14, 0, 0);
    check("t2_status", 96'(rdata), 96'(3));
    apply_stimulus(0, 0, 8'h00, 0, 1);
    apply_stimulus(0, 0, 8'h00, 0, 0);
    apply_stimulus(0, 0, 8'h00, 0, 0);
    check("t2_req2", 96'(req), 96'(1));
    check("t2_note_new", 96'(note_en), 96'(1));
    apply_stimulus(0, 0, 8'h00, 0, 1);
    apply_stimulus(0, 0, 8'h00, 0, 0);
    drain();
    apply_stimulus(0, 1, 8'h14, 0, 0);
    check("t2_status_end", 96'(rdata), 96'(0));

    // Highest carrier voice and out-of-range voice
    apply_stimulus(1, 0, 8'h4C, 32'h00AB_CDEF, 0);
    apply_stimulus(1, 0, 8'h10, 0, 0);
    check("t3_carrier3", 96'(carrier_fcws[95:72]), 96'(24'hABCDEF));
    drain();
    apply_stimulus(1, 0, 8'h50, 32'h0077_7777, 0);
    apply_stimulus(0, 1, 8'h50, 0, 0);
    check("t3_oob_read", 96'(rdata), 96'(0));
    drain();

    // ack while idle has no effect
    apply_stimulus(0, 0, 8'h00, 0, 1);
    check("t4_idle_ack", 96'(req), 96'(0));
    apply_stimulus(0, 0, 8'h00, 0, 0);

    // Asynchronous reset in the middle of a handshake
    apply_stimulus(1, 0, 8'h10, 0, 0);
    check("t5_req_before", 96'(req), 96'(1));
    #2 rst = 1'b1;
    #1;
    model_reset();
    check("t5_req_async", 96'(req), 96'(0));
    check("t5_fcw_async", 96'(mod_fcw), 96'(0));
    check("t5_car_async", 96'(carrier_fcws), 96'(0));
    check("t5_note_async", 96'(note_en), 96'(0));
    @(negedge clk);
    rst = 1'b0;
    apply_stimulus(0, 1, 8'h40, 0, 0);
    check("t5_shadow_clr", 96'(rdata), 96'(0));

    // Shadow write alone: commits only with auto-commit
    apply_stimulus(1, 0, 8'h04, 32'h1F, 0);
`ifdef SYNTH_CFG_AUTO_COMMIT_EN
    check("t6_auto_req", 96'(req), 96'(1));
    check("t6_auto_shift", 96'(mod_shift), 96'(5'h1F));
`else
    check("t6_no_auto_req", 96'(req), 96'(0));
    check("t6_no_auto_shift", 96'(mod_shift), 96'(0));
`endif
    drain();

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      a = addr_pool[$urandom_range(0, 11)] | 8'($urandom_range(0, 3));
      apply_stimulus(($urandom_range(0, 2) == 0), ($urandom_range(0, 1) == 1), a, $urandom,
                     ($urandom_range(0, 2) == 0));
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
